oc8051_xram_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single XRAM port among up to 8 bus masters (CPU, DMA, crypto engines).

---
 rtl/oc8051_xram_arbiter.sv | 110 +++++++++++
 tb/tb_oc8051_xram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/oc8051_xram_arbiter.sv
// oc8051_xram_arbiter: round-robin arbiter giving up to 8 masters page-table-checked access to the XRAM port
module oc8051_xram_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_stb,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [16*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]    req_data_in,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_err,
    output logic [7:0]           req_data_out,
    output logic [15:0]          xram_addr,
    output logic                 xram_wr,
    output logic [7:0]           xram_data_out,
    output logic                 chk_stb,
    output logic [2:0]           accesser,
    input  logic                 pt_wr_en,
    input  logic                 pt_rd_en,
    output logic                 mem_stb,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_data_in,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, CHECK, ACCESS, DONE, DENY} state_t;
    state_t          state, state_nx;
    logic [2:0]      ptr, gnt;
    logic            found;
    logic [7:0]      req8;
    logic [7:0]      cnt;
    logic [NREQ-1:0] gnt_oh;
    logic [15:0]     g_addr;
    logic            g_wr;
    logic [7:0]      g_data;
    logic            perm, tmo;

    assign req8 = 8'(req_stb);
    // search starts just after the last grant so a persistent requester cannot starve the others
    always_comb begin
        found = 1'b0;
        gnt   = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req8[3'((int'(ptr) + k) % NREQ)]) begin
                found = 1'b1;
                gnt   = 3'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        g_addr = '0;
        g_wr   = 1'b0;
        g_data = '0;
        gnt_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == 3'(i)) begin
                g_addr = req_addr[16*i +: 16];
                g_wr   = req_wr[i];
                g_data = req_data_in[8*i +: 8];
            end
            gnt_oh[i] = (accesser == 3'(i));
        end
    end

    assign perm    = xram_wr ? pt_wr_en : pt_rd_en;
    assign tmo     = (cnt == 8'(TIMEOUT - 1));
    assign chk_stb = (state == CHECK);
    assign mem_stb = (state == ACCESS);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? CHECK : IDLE;
            CHECK:   state_nx = perm ? ACCESS : DENY;
            ACCESS:  state_nx = mem_ack ? DONE : (tmo ? DENY : ACCESS);
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 3'(NREQ - 1);
            cnt           <= '0;
            accesser      <= '0;
            xram_addr     <= '0;
            xram_wr       <= 1'b0;
            xram_data_out <= '0;
            req_ack       <= '0;
            req_err       <= '0;
            req_data_out  <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= (state == ACCESS) ? cnt + 8'd1 : 8'd0;
            req_ack      <= (state_nx == DONE || state_nx == DENY) ? gnt_oh : '0;
            req_err      <= (state_nx == DENY) ? gnt_oh : '0;
            req_data_out <= (state == ACCESS && mem_ack && !xram_wr) ? mem_data_in : 8'h00;
            if (state == IDLE && found) begin
                ptr           <= gnt;
                accesser      <= gnt;
                xram_addr     <= g_addr;
                xram_wr       <= g_wr;
                xram_data_out <= g_data;
            end
        end
    end
endmodule

// File: tb/tb_oc8051_xram_arbiter.sv
// tb_oc8051_xram_arbiter: directed scenario tests for the XRAM arbiter
module tb_oc8051_xram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_stb = '0;
    logic [3:0]  req_wr = '0;
    logic [63:0] req_addr = '0;
    logic [31:0] req_data_in = '0;
    logic [3:0]  req_ack, req_err;
    logic [7:0]  req_data_out;
    logic [15:0] xram_addr;
    logic        xram_wr;
    logic [7:0]  xram_data_out;
    logic        chk_stb;
    logic [2:0]  accesser;
    logic        pt_wr_en = 1'b0;
    logic        pt_rd_en = 1'b0;
    logic        mem_stb;
    logic        mem_ack;
    logic [7:0]  mem_data_in = '0;
    logic        busy;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    // zero-wait memory model when auto_ack is set
    assign mem_ack = auto_ack ? mem_stb : man_ack;

    oc8051_xram_arbiter #(.NREQ(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_stb(req_stb), .req_wr(req_wr), .req_addr(req_addr),
        .req_data_in(req_data_in), .req_ack(req_ack), .req_err(req_err), .req_data_out(req_data_out),
        .xram_addr(xram_addr), .xram_wr(xram_wr), .xram_data_out(xram_data_out), .chk_stb(chk_stb),
        .accesser(accesser), .pt_wr_en(pt_wr_en), .pt_rd_en(pt_rd_en), .mem_stb(mem_stb),
        .mem_ack(mem_ack), .mem_data_in(mem_data_in), .busy(busy)
    );

    always #5 clk = ~clk;

    int         ack_cyc, chk_cnt, stb_cnt;
    logic [3:0] ack_v, err_v;
    logic [7:0] dat_v, x_data;
    logic [2:0] acc_seen;
    logic [15:0] x_addr;
    logic       x_wr;

    // steps until req_ack appears, recording what was seen; requester drops on the ack edge
    task automatic observe(input int limit);
        bit done = 0;
        ack_cyc = -1; chk_cnt = 0; stb_cnt = 0; ack_v = '0; err_v = '0; dat_v = '0;
        acc_seen = '0; x_addr = '0; x_wr = 1'b0; x_data = '0;
        for (int c = 1; c <= limit && !done; c++) begin
            @(negedge clk);
            if (chk_stb) begin chk_cnt++; acc_seen = accesser; end
            if (mem_stb) begin stb_cnt++; x_addr = xram_addr; x_wr = xram_wr; x_data = xram_data_out; end
            if (req_ack != 0) begin
                ack_cyc = c; ack_v = req_ack; err_v = req_err; dat_v = req_data_out;
                req_stb = req_stb & ~req_ack;
                done = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({req_ack, req_err, req_data_out, xram_addr, xram_wr, xram_data_out, chk_stb, accesser, mem_stb, busy} !== '0) begin
            fails++; $display("FAIL reset_outputs: got ack=%h err=%h data=%h addr=%h busy=%b, required all zero",
                              req_ack, req_err, req_data_out, xram_addr, busy);
        end
    endtask

    task automatic test_read_ok();
        @(negedge clk);
        auto_ack = 1'b1; pt_rd_en = 1'b1; pt_wr_en = 1'b0; mem_data_in = 8'hA5;
        req_wr[0] = 1'b0; req_addr[15:0] = 16'h1234; req_stb = 4'b0001;
        observe(10);
        tests++; if (ack_cyc !== 3) begin fails++; $display("FAIL read_latency: got %0d, required 3", ack_cyc); end
        tests++; if (ack_v !== 4'b0001) begin fails++; $display("FAIL read_ack: got %b, required 0001", ack_v); end
        tests++; if (err_v !== 4'b0000) begin fails++; $display("FAIL read_err: got %b, required 0000", err_v); end
        tests++; if (dat_v !== 8'hA5) begin fails++; $display("FAIL read_data: got %h, required a5", dat_v); end
        tests++; if (x_addr !== 16'h1234) begin fails++; $display("FAIL read_addr: got %h, required 1234", x_addr); end
        tests++; if (chk_cnt !== 1) begin fails++; $display("FAIL read_chk_count: got %0d, required 1", chk_cnt); end
        @(negedge clk);
        tests++; if ({req_ack, busy, req_data_out} !== '0) begin
            fails++; $display("FAIL read_after: got ack=%b busy=%b data=%h, required 0", req_ack, busy, req_data_out); end
    endtask

    task automatic test_denied_write();
        @(negedge clk);
        auto_ack = 1'b1; pt_wr_en = 1'b0; pt_rd_en = 1'b1;
        req_wr[2] = 1'b1; req_addr[47:32] = 16'hFF80; req_data_in[23:16] = 8'h77; req_stb = 4'b0100;
        observe(10);
        tests++; if (ack_cyc !== 2) begin fails++; $display("FAIL deny_latency: got %0d, required 2", ack_cyc); end
        tests++; if (ack_v !== 4'b0100 || err_v !== 4'b0100) begin
            fails++; $display("FAIL deny_ack_err: got ack=%b err=%b, required 0100/0100", ack_v, err_v); end
        tests++; if (chk_cnt !== 1) begin fails++; $display("FAIL deny_chk_count: got %0d, required 1", chk_cnt); end
        tests++; if (acc_seen !== 3'd2) begin fails++; $display("FAIL deny_accesser: got %0d, required 2", acc_seen); end
        tests++; if (stb_cnt !== 0) begin fails++; $display("FAIL deny_mem_stb: got %0d cycles, required 0", stb_cnt); end
        tests++; if (dat_v !== 8'h00) begin fails++; $display("FAIL deny_data: got %h, required 00", dat_v); end
        req_wr = '0;
    endtask

    task automatic test_round_robin();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        int g;
        do_reset();
        auto_ack = 1'b1; pt_rd_en = 1'b1; mem_data_in = 8'h11;
        for (int i = 0; i < 5; i++) begin
            req_stb = 4'b1111;
            observe(12);
            g = -1;
            for (int k = 0; k < 4; k++) if (ack_v[k]) g = k;
            tests++; if (g !== exp_g[i] || err_v !== 4'b0000) begin
                fails++; $display("FAIL rr_grant_%0d: got %0d err=%b, required %0d err=0000", i, g, err_v, exp_g[i]); end
        end
        req_stb = '0;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        auto_ack = 1'b0; man_ack = 1'b0; pt_rd_en = 1'b1;
        req_wr[3] = 1'b0; req_addr[63:48] = 16'h4000; req_stb = 4'b1000;
        observe(20);
        tests++; if (stb_cnt !== 4) begin fails++; $display("FAIL tmo_stb_cycles: got %0d, required 4", stb_cnt); end
        tests++; if (ack_cyc !== 6) begin fails++; $display("FAIL tmo_latency: got %0d, required 6", ack_cyc); end
        tests++; if (ack_v !== 4'b1000 || err_v !== 4'b1000) begin
            fails++; $display("FAIL tmo_ack_err: got ack=%b err=%b, required 1000/1000", ack_v, err_v); end
        man_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++; if ({req_ack, req_err, mem_stb, busy} !== '0) begin
            fails++; $display("FAIL tmo_late_ack: got ack=%b err=%b stb=%b busy=%b, required 0", req_ack, req_err, mem_stb, busy); end
        man_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        auto_ack = 1'b0; man_ack = 1'b0; pt_rd_en = 1'b1;
        req_wr[1] = 1'b0; req_addr[31:16] = 16'h2222; req_stb = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        tests++; if (mem_stb !== 1'b1) begin fails++; $display("FAIL mid_access: got mem_stb=%b, required 1", mem_stb); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if ({busy, mem_stb, req_ack, req_err} !== '0) begin
            fails++; $display("FAIL mid_reset: got busy=%b stb=%b ack=%b err=%b, required 0", busy, mem_stb, req_ack, req_err); end
        rst = 1'b0; req_stb = '0;
        @(negedge clk);
        auto_ack = 1'b1; mem_data_in = 8'h5A;
        req_wr[3] = 1'b0; req_stb = 4'b1010;
        observe(10);
        tests++; if (ack_v !== 4'b0010 || acc_seen !== 3'd1) begin
            fails++; $display("FAIL mid_regrant: got ack=%b accesser=%0d, required 0010/1", ack_v, acc_seen); end
        tests++; if (dat_v !== 8'h5A) begin fails++; $display("FAIL mid_regrant_data: got %h, required 5a", dat_v); end
        observe(10);
        tests++; if (ack_v !== 4'b1000) begin fails++; $display("FAIL mid_second: got %b, required 1000", ack_v); end
        req_stb = '0;
    endtask

    task automatic test_write_ok();
        @(negedge clk);
        auto_ack = 1'b1; pt_wr_en = 1'b1; pt_rd_en = 1'b0; mem_data_in = 8'hEE;
        req_wr[1] = 1'b1; req_addr[31:16] = 16'h0100; req_data_in[15:8] = 8'h3C; req_stb = 4'b0010;
        observe(10);
        tests++; if (x_wr !== 1'b1 || x_data !== 8'h3C || x_addr !== 16'h0100) begin
            fails++; $display("FAIL wr_bus: got wr=%b data=%h addr=%h, required 1/3c/0100", x_wr, x_data, x_addr); end
        tests++; if (ack_cyc !== 3 || ack_v !== 4'b0010 || err_v !== 4'b0000) begin
            fails++; $display("FAIL wr_ack: got cyc=%0d ack=%b err=%b, required 3/0010/0000", ack_cyc, ack_v, err_v); end
        tests++; if (dat_v !== 8'h00) begin fails++; $display("FAIL wr_data_out: got %h, required 00", dat_v); end
        req_stb = '0; req_wr = '0;
    endtask

    initial begin
        test_reset();
        test_read_ok();
        test_denied_write();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_write_ok();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
